// File: rtl/fifo_read_ctrl_param_if.sv
// Read-port bundle of the async FIFO read controller: consumer handshake, synchronised
// write pointer in, read pointers/flags out. RD_UNDERFLOW_CNT_EN adds underflow_cnt.
interface fifo_read_ctrl_param_if #(
   parameter int ADDR_W = 4
);
   logic              enable_rd;
   logic [ADDR_W:0]   wr_ptr_gray_s;
   logic              underflow_clr;
   logic              enable_rd_out;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W-1:0] b_rd_ptr;
   logic              MSB_rd_ptr;
   logic [ADDR_W:0]   rd_ptr_gray;
   logic              f_empty;
   logic              f_aempty;
   logic [ADDR_W:0]   rd_count;
   logic              underflow;
`ifdef RD_UNDERFLOW_CNT_EN
   logic [7:0]        underflow_cnt;
`endif

   // Controller side.
   modport slave (
      input  enable_rd, wr_ptr_gray_s, underflow_clr,
      output enable_rd_out, rd_ptr, b_rd_ptr, MSB_rd_ptr, rd_ptr_gray,
             f_empty, f_aempty, rd_count, underflow
`ifdef RD_UNDERFLOW_CNT_EN
      , output underflow_cnt
`endif
   );

   // Consumer / pointer-source side.
   modport master (
      output enable_rd, wr_ptr_gray_s, underflow_clr,
      input  enable_rd_out, rd_ptr, b_rd_ptr, MSB_rd_ptr, rd_ptr_gray,
             f_empty, f_aempty, rd_count, underflow
`ifdef RD_UNDERFLOW_CNT_EN
      , input underflow_cnt
`endif
   );
endinterface

// File: rtl/fifo_read_ctrl_param.sv
// Async FIFO read-side controller: read qualification, binary/Gray read pointers, registered
// empty/almost-empty/count flags and sticky underflow. RD_UNDERFLOW_CNT_EN adds underflow_cnt.
module fifo_read_ctrl_param #(
   parameter int ADDR_W    = 4,
   parameter int AEMPTY_TH = 2
) (
   input logic                   rd_clk,
   input logic                   reset_n,
   fifo_read_ctrl_param_if.slave bus
);
   localparam int               PTR_W      = ADDR_W + 1;
   localparam logic [PTR_W-1:0] AEMPTY_LIM = PTR_W'(AEMPTY_TH);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
   logic [PTR_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_bin;
   logic             f_empty_q, f_empty_d;
   logic             f_aempty_q, f_aempty_d;
   logic             underflow_q, underflow_d;
   logic             rd_fire, rd_starved;

   // Flags are registered, so a read is only ever qualified against last cycle's empty.
   assign rd_fire    = bus.enable_rd & ~f_empty_q;
   assign rd_starved = bus.enable_rd &  f_empty_q;

   assign rd_ptr_d   = rd_ptr_q + PTR_W'(rd_fire);
   assign rd_gray_d  = rd_ptr_d ^ (rd_ptr_d >> 1);
   assign f_empty_d  = (rd_gray_d == bus.wr_ptr_gray_s);
   assign count_d    = wr_bin - rd_ptr_d;
   assign f_aempty_d = (count_d <= AEMPTY_LIM);

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      wr_bin = '0;
      for (int i = 0; i < PTR_W; i++) begin
         wr_bin[i] = ^(bus.wr_ptr_gray_s >> i);
      end
   end

   always_comb begin
      underflow_d = underflow_q;
      if (rd_starved) begin
         underflow_d = 1'b1;
      end else if (bus.underflow_clr) begin
         underflow_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same edge.
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q    <= '0;
         rd_gray_q   <= '0;
         count_q     <= '0;
         f_empty_q   <= 1'b1;
         f_aempty_q  <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         rd_gray_q   <= rd_gray_d;
         count_q     <= count_d;
         f_empty_q   <= f_empty_d;
         f_aempty_q  <= f_aempty_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.enable_rd_out = rd_fire;
   assign bus.rd_ptr        = rd_ptr_q;
   assign bus.b_rd_ptr      = rd_ptr_q[ADDR_W-1:0];
   assign bus.MSB_rd_ptr    = rd_ptr_q[ADDR_W];
   assign bus.rd_ptr_gray   = rd_gray_q;
   assign bus.f_empty       = f_empty_q;
   assign bus.f_aempty      = f_aempty_q;
   assign bus.rd_count      = count_q;
   assign bus.underflow     = underflow_q;

`ifdef RD_UNDERFLOW_CNT_EN
   logic [7:0] ucnt_q, ucnt_d;

   // A starved request always beats a clear; at 255 the count simply holds.
   always_comb begin
      ucnt_d = ucnt_q;
      if (rd_starved) begin
         if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
      end else if (bus.underflow_clr) begin
         ucnt_d = '0;
      end
   end

   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) ucnt_q <= '0;
      else          ucnt_q <= ucnt_d;
   end

   assign bus.underflow_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_fifo_read_ctrl_param.sv
// Self-checking bench for fifo_read_ctrl_param (ADDR_W=4, AEMPTY_TH=2): directed scenarios plus
// random traffic against a model that tracks total reads/writes as plain integers.
module tb_fifo_read_ctrl_param;
   localparam int ADDR_W    = 4;
   localparam int AEMPTY_TH = 2;
   localparam int PTR_W     = ADDR_W + 1;
   localparam int DEPTH     = 2 ** ADDR_W;
   localparam int OBS_W     = 3 * PTR_W + ADDR_W + 4;
   localparam logic [OBS_W-1:0] RESET_VEC = {PTR_W'(0), ADDR_W'(0), 1'b0, PTR_W'(0),
                                             1'b1, 1'b1, PTR_W'(0), 1'b0};

   logic rd_clk  = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   fifo_read_ctrl_param_if #(.ADDR_W(ADDR_W)) bus ();

   fifo_read_ctrl_param #(.ADDR_W(ADDR_W), .AEMPTY_TH(AEMPTY_TH)) u_dut (
      .rd_clk  (rd_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 rd_clk = ~rd_clk;

   // Reference model: counts of words written and read since reset.
   int m_rd, m_wr, m_count, m_ucnt;
   bit m_empty, m_aempty, m_underflow;
   bit cur_en, cur_clr;

   function automatic logic [PTR_W-1:0] to_gray(input int x);
      logic [PTR_W-1:0] b;
      b = PTR_W'(x % (2 * DEPTH));
      return b ^ (b >> 1);
   endfunction

   function automatic logic [OBS_W-1:0] obs_vec();
      return {bus.rd_ptr, bus.b_rd_ptr, bus.MSB_rd_ptr, bus.rd_ptr_gray,
              bus.f_empty, bus.f_aempty, bus.rd_count, bus.underflow};
   endfunction

   function automatic logic [OBS_W-1:0] exp_vec();
      logic [PTR_W-1:0] rp;
      rp = PTR_W'(m_rd % (2 * DEPTH));
      return {rp, rp[ADDR_W-1:0], rp[ADDR_W], to_gray(m_rd),
              m_empty, m_aempty, PTR_W'(m_count), m_underflow};
   endfunction

   task automatic model_reset();
      m_rd = 0; m_wr = 0; m_count = 0; m_ucnt = 0;
      m_empty = 1'b1; m_aempty = 1'b1; m_underflow = 1'b0;
      cur_en = 1'b0; cur_clr = 1'b0;
   endtask

   task automatic drive(input bit en, input int wr_tgt, input bit clr);
      @(negedge rd_clk);
      bus.enable_rd     = en;
      bus.wr_ptr_gray_s = to_gray(wr_tgt);
      bus.underflow_clr = clr;
      cur_en = en; cur_clr = clr; m_wr = wr_tgt;
      #1;
   endtask

   task automatic tick();
      bit fire, starved;
      fire    = cur_en && !m_empty;
      starved = cur_en && m_empty;
      @(posedge rd_clk);
      if (fire) m_rd++;
      m_count  = m_wr - m_rd;
      m_empty  = (m_count == 0);
      m_aempty = (m_count <= AEMPTY_TH);
      if (starved)      m_underflow = 1'b1;
      else if (cur_clr) m_underflow = 1'b0;
      if (starved) begin
         if (m_ucnt < 255) m_ucnt++;
      end else if (cur_clr) begin
         m_ucnt = 0;
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge rd_clk);
      reset_n = 1'b0;
      bus.enable_rd = 1'b0; bus.wr_ptr_gray_s = '0; bus.underflow_clr = 1'b0;
      model_reset();
      @(negedge rd_clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.enable_rd = 1'b1; bus.wr_ptr_gray_s = to_gray(3); bus.underflow_clr = 1'b0;
      reset_n = 1'b0;
      @(posedge rd_clk); #1;
      checks++;
      if (obs_vec() !== RESET_VEC) begin
         errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), RESET_VEC);
      end
      checks++;
      if (bus.enable_rd_out !== 1'b0) begin
         errors++; $display("FAIL reset_rd_out: got %b expected 0", bus.enable_rd_out);
      end
      bus.enable_rd = 1'b0; bus.wr_ptr_gray_s = '0;
      model_reset();
      @(negedge rd_clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fill_drain();
      drive(1'b0, 5, 1'b0); tick();
      checks++;
      if (bus.rd_count !== 5'd5 || bus.f_empty !== 1'b0 || bus.f_aempty !== 1'b0) begin
         errors++; $display("FAIL fill5: got count=%0d empty=%b aempty=%b expected 5/0/0",
                            bus.rd_count, bus.f_empty, bus.f_aempty);
      end
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 5, 1'b0);
         checks++;
         if (bus.enable_rd_out !== 1'b1) begin
            errors++; $display("FAIL drain_rd_out%0d: got %b expected 1", i, bus.enable_rd_out);
         end
         tick();
         checks++;
         if (bus.rd_count !== PTR_W'(5 - i) || bus.f_aempty !== ((5 - i) <= AEMPTY_TH)) begin
            errors++; $display("FAIL drain_count%0d: got count=%0d aempty=%b expected %0d/%b",
                               i, bus.rd_count, bus.f_aempty, 5 - i, (5 - i) <= AEMPTY_TH);
         end
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL drain_vec%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (bus.f_empty !== 1'b1) begin
         errors++; $display("FAIL drain_empty: got %b expected 1", bus.f_empty);
      end
      drive(1'b1, 5, 1'b0);
      checks++;
      if (bus.enable_rd_out !== 1'b0) begin
         errors++; $display("FAIL read_when_empty: got %b expected 0", bus.enable_rd_out);
      end
      tick();
      drive(1'b0, 5, 1'b1); tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL drain_end: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap_full();
      logic [PTR_W-1:0] prev;
      apply_reset();
      drive(1'b0, DEPTH, 1'b0); tick();
      checks++;
      if (bus.rd_count !== PTR_W'(DEPTH) || bus.f_empty !== 1'b0 || bus.f_aempty !== 1'b0) begin
         errors++; $display("FAIL full: got count=%0d empty=%b aempty=%b expected 16/0/0",
                            bus.rd_count, bus.f_empty, bus.f_aempty);
      end
      for (int lap = 1; lap <= 2; lap++) begin
         if (lap == 2) begin
            drive(1'b0, 2 * DEPTH, 1'b0); tick();
         end
         for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, lap * DEPTH, 1'b0);
            prev = bus.rd_ptr_gray;
            tick();
            checks++;
            if ($countones(prev ^ bus.rd_ptr_gray) > 1) begin
               errors++; $display("FAIL gray_step: got %b -> %b expected at most one bit change",
                                  prev, bus.rd_ptr_gray);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL wrap_vec: got %h expected %h", obs_vec(), exp_vec());
            end
         end
         checks++;
         if (bus.rd_ptr !== PTR_W'((lap * DEPTH) % (2 * DEPTH)) || bus.b_rd_ptr !== '0 ||
             bus.MSB_rd_ptr !== (lap == 1) || bus.f_empty !== 1'b1) begin
            errors++; $display("FAIL wrap_lap%0d: got ptr=%0d b=%0d msb=%b empty=%b expected %0d/0/%b/1",
                               lap, bus.rd_ptr, bus.b_rd_ptr, bus.MSB_rd_ptr, bus.f_empty,
                               (lap * DEPTH) % (2 * DEPTH), lap == 1);
         end
      end
   endtask

   task automatic test_underflow();
      bit exp_uf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      bit en_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bit clr_seq[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(en_seq[i], m_wr, clr_seq[i]); tick();
         checks++;
         if (bus.underflow !== exp_uf[i] || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL underflow_step%0d: got uf=%b vec=%h expected uf=%b vec=%h",
                               i, bus.underflow, obs_vec(), exp_uf[i], exp_vec());
         end
      end
`ifdef RD_UNDERFLOW_CNT_EN
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, m_wr, i[0]); tick();
      end
      checks++;
      if (bus.underflow_cnt !== 8'd255 || m_ucnt != 255) begin
         errors++; $display("FAIL underflow_cnt_sat: got %0d expected 255", bus.underflow_cnt);
      end
      drive(1'b0, m_wr, 1'b1); tick();
      checks++;
      if (bus.underflow_cnt !== 8'd0) begin
         errors++; $display("FAIL underflow_cnt_clr: got %0d expected 0", bus.underflow_cnt);
      end
`endif
   endtask

   task automatic test_simultaneous();
      drive(1'b0, m_wr + 1, 1'b0); tick();
      drive(1'b1, m_wr + 1, 1'b0);
      checks++;
      if (bus.enable_rd_out !== 1'b1) begin
         errors++; $display("FAIL simul_rd_out: got %b expected 1", bus.enable_rd_out);
      end
      tick();
      checks++;
      if (bus.rd_count !== 5'd1 || bus.f_empty !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL simul_rw: got count=%0d empty=%b vec=%h expected 1/0/%h",
                            bus.rd_count, bus.f_empty, obs_vec(), exp_vec());
      end
   endtask

   task automatic test_midreset();
      apply_reset();
      drive(1'b0, 10, 1'b0); tick();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 10, 1'b0); tick();
      end
      checks++;
      if (bus.rd_ptr !== 5'd7) begin
         errors++; $display("FAIL midreset_setup: got rd_ptr=%0d expected 7", bus.rd_ptr);
      end
      drive(1'b1, 10, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== RESET_VEC || bus.enable_rd_out !== 1'b0) begin
         errors++; $display("FAIL midreset: got %h rd_out=%b expected %h rd_out=0",
                            obs_vec(), bus.enable_rd_out, RESET_VEC);
      end
      @(negedge rd_clk);
      bus.enable_rd = 1'b0; bus.wr_ptr_gray_s = '0; bus.underflow_clr = 1'b0;
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      bit en, clr;
      int wr_tgt;
      for (int i = 0; i < 500; i++) begin
         en     = ($urandom_range(0, 3) != 0);
         clr    = ($urandom_range(0, 7) == 0);
         wr_tgt = m_wr + int'($urandom_range(0, 2));
         if (wr_tgt > m_rd + DEPTH) wr_tgt = m_rd + DEPTH;
         drive(en, wr_tgt, clr);
         checks++;
         if (bus.enable_rd_out !== (en && !m_empty)) begin
            errors++; $display("FAIL rand_rd_out%0d: got %b expected %b",
                               i, bus.enable_rd_out, en && !m_empty);
         end
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rand_vec%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
`ifdef RD_UNDERFLOW_CNT_EN
         checks++;
         if (bus.underflow_cnt !== 8'(m_ucnt)) begin
            errors++; $display("FAIL rand_ucnt%0d: got %0d expected %0d", i, bus.underflow_cnt, m_ucnt);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap_full();
      test_underflow();
      test_simultaneous();
      test_midreset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $fatal(1);
   end
endmodule
